// File: rtl/seq_comparator_ctrl.sv
// Serial unsigned comparator, 2-bit digit per cycle, MSB digit first.
// Optional EARLY_EXIT_EN: finish on the first differing digit pair.
module seq_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Lesser,
    output logic             Greater,
    output logic             Equal,
    output logic [4:0]       steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [4:0] NDIG = 5'(WIDTH / 2);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [4:0]       r_idx;
    logic [4:0]       r_steps;
    logic             r_found;
    logic             r_dir_gt;
    logic             r_lt;
    logic             r_gt;
    logic             r_eq;

    logic [1:0]       w_da;
    logic [1:0]       w_db;
    logic             w_diff;
    logic             w_last;
    logic             w_exit;
    logic             w_any;
    logic             w_gt;

    // Operands shift left each step, so the current digit is always on top
    assign w_da   = r_a[WIDTH-1 -: 2];
    assign w_db   = r_b[WIDTH-1 -: 2];
    assign w_diff = (w_da != w_db);
    assign w_last = (r_idx == 5'd0);
    assign w_any  = r_found || w_diff;
    assign w_gt   = r_found ? r_dir_gt : (w_da > w_db);

    always_comb begin
        w_next = r_state;
        w_exit = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CMP;
            end
            S_CMP: begin
                if (w_last) w_exit = 1'b1;
`ifdef EARLY_EXIT_EN
                if (w_diff) w_exit = 1'b1;
`endif
                if (w_exit) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_steps  <= '0;
            r_found  <= 1'b0;
            r_dir_gt <= 1'b0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_idx    <= NDIG - 5'd1;
                        r_steps  <= '0;
                        r_found  <= 1'b0;
                        r_dir_gt <= 1'b0;
                        r_lt     <= 1'b0;
                        r_gt     <= 1'b0;
                        r_eq     <= 1'b0;
                    end
                end
                S_CMP: begin
                    r_a     <= r_a << 2;
                    r_b     <= r_b << 2;
                    r_idx   <= r_idx - 5'd1;
                    r_steps <= r_steps + 5'd1;
                    if (!r_found && w_diff) begin
                        r_found  <= 1'b1;
                        r_dir_gt <= (w_da > w_db);
                    end
                    // Flags are published only once, on the edge entering DONE
                    if (w_exit) begin
                        r_gt <= w_any && w_gt;
                        r_lt <= w_any && !w_gt;
                        r_eq <= !w_any;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign Lesser  = r_lt;
    assign Greater = r_gt;
    assign Equal   = r_eq;
    assign steps   = r_steps;

endmodule

// File: doc/seq_comparator_ctrl.md
SEQ_COMPARATOR_CTRL -- requirements
Module: seq_comparator_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are even, 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a compare; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B, unsigned.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the result flags are valid.
REQ-009 The block SHALL have ports Lesser, Greater and Equal, outputs, 1 bit each: the registered compare result (A<B, A>B, A==B).
REQ-010 The block SHALL have port steps, output, 5 bits: the number of 2-bit digit slices evaluated in the last compare.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, CMP and DONE; the encoding is free.
REQ-012 In IDLE, start=1 at a clock edge SHALL load A and B into internal registers, set digit index to WIDTH/2-1, clear steps and go to CMP.
REQ-013 While start=0 in IDLE, the FSM SHALL stay in IDLE.
REQ-014 start SHALL be ignored in CMP and DONE: no re-capture and no queuing.
REQ-015 Each CMP edge SHALL compare one 2-bit digit of the captured A and B, MSB digit first, and decrement the index.
REQ-016 Each CMP edge SHALL increment steps by 1.
REQ-017 Before any differing digit is found, the first digit pair that differs SHALL fix the outcome; later digits SHALL NOT change it.
REQ-018 If no digit pair differs, the outcome SHALL be Equal.
REQ-019 CMP SHALL go to DONE on the edge that evaluates digit index 0; REQ-031 adds an early exit.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE on the next edge.
REQ-021 In the DONE cycle, exactly one of Lesser, Greater and Equal SHALL be 1.
REQ-022 Lesser, Greater, Equal and steps SHALL hold their values until the next start is accepted in IDLE, or until reset.
REQ-023 Changes on A and B after capture SHALL NOT affect the result in progress.
REQ-024 For WIDTH=2, CMP SHALL last exactly one cycle.
REQ-025 Latency SHALL be as follows: with the start-accept edge at edge 0, done is high in the cycle after the edge that completes the final slice.
REQ-026 With early exit disabled, done SHALL be high exactly WIDTH/2 cycles after the start-accept edge.
REQ-027 A new start SHALL be accepted no earlier than the IDLE cycle following DONE.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and set busy, done, Lesser, Greater and Equal to 0 and steps to 0.
REQ-029 Reset SHALL take priority over start and over every FSM transition.
REQ-030 rst_n asserted during CMP or DONE SHALL abort the compare, produce no done pulse and clear the result; the block SHALL accept start on the first edge with rst_n=1.

Configuration
REQ-031 Macro EARLY_EXIT_EN defined: CMP SHALL go to DONE on the edge that finds the first differing digit pair, so steps equals the 1-based position of that digit from the MSB.
REQ-032 Macro EARLY_EXIT_EN undefined: CMP SHALL always evaluate all WIDTH/2 digits, so steps always equals WIDTH/2 and latency is fixed.

Verification
REQ-033 Reset scenario: rst_n=0 for 2 cycles, then released -> busy=0, done=0, Lesser=Greater=Equal=0, steps=0.
REQ-034 Equal scenario: WIDTH=8, A=8'hA5, B=8'hA5, start pulse -> done after 4 cycles with Equal=1 and steps=4, in both configurations.
REQ-035 MSB-differ scenario: A=8'hC0, B=8'h3F -> Greater=1; with EARLY_EXIT_EN, done after 1 cycle and steps=1; without it, done after 4 cycles and steps=4.
REQ-036 LSB-differ scenario: A=8'h12, B=8'h13 -> Lesser=1, steps=4, done after 4 cycles in both configurations; start re-pulsed mid-compare is ignored.
REQ-037 Abort scenario: start with A=8'hFF, B=8'h00, then rst_n=0 on the second CMP edge -> no done pulse and all flags 0; a fresh start right after release gives Greater=1.
REQ-038 Operand-hold scenario: A and B changed to random values every cycle after capture, including a back-to-back start on the IDLE cycle after DONE -> the result matches the captured values and the second compare is accepted.
